// File: rtl/clkdiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : clkdiv_ctrl
// Brief  : Two-requester arbiter that ramps a downstream divider ratio one
//          settled step at a time.
// Rev    : 1.0  initial release
// ============================================================================
module clkdiv_ctrl #(
    parameter int n         = 8,
    parameter int div_init  = 4,
    parameter int step_wait = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [n-1:0] div0,
    input  logic [n-1:0] div1,
    input  logic         busy,
    output logic [n-1:0] div,
    output logic [1:0]   gnt,
    output logic         done,
    output logic         active
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [n-1:0] c_DIV_INIT  = n'(div_init);
    localparam logic [n-1:0] c_ZERO      = '0;
    localparam logic [n-1:0] c_ONE       = n'(1);
    localparam logic [7:0]   c_HOLD_LOAD = 8'(step_wait);
    localparam logic [9:0]   c_WAIT_LAST = 10'd1023;

    logic [2:0]   state_q, state_d;
    logic [n-1:0] div_q, div_d;
    logic [n-1:0] tgt_q, tgt_d;
    logic [7:0]   hold_q, hold_d;
    logic [9:0]   wait_q, wait_d;
    logic [1:0]   gnt_q, gnt_d;
    logic         last_q, last_d;
    logic         start_q;
    logic         busy_meta_q, busy_s_q;
    logic         w_pick;

    // Index of the winner: on a tie, the requester not served last.
    assign w_pick = (req == 2'b11) ? ~last_q : req[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            div_q       <= c_DIV_INIT;
            tgt_q       <= c_DIV_INIT;
            hold_q      <= 8'd0;
            wait_q      <= 10'd0;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            start_q     <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tgt_q       <= tgt_d;
            hold_q      <= hold_d;
            wait_q      <= wait_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            start_q     <= 1'b1;
            busy_meta_q <= busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        gnt_d   = 2'b00;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                // start_q keeps the first grant off the first edge after reset.
                if (start_q && (req != 2'b00)) begin
                    gnt_d   = w_pick ? 2'b10 : 2'b01;
                    last_d  = w_pick;
                    tgt_d   = w_pick ? div1 : div0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (div_q == tgt_q) begin
                    state_d = S_FIN;
                end else begin
                    if ((tgt_q == c_ZERO) || (div_q == c_ZERO)) begin
                        div_d = tgt_q;
                    end else if (tgt_q > div_q) begin
                        div_d = div_q + c_ONE;
                    end else begin
                        div_d = div_q - c_ONE;
                    end
                    wait_d  = 10'd0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (busy_s_q) begin
                    state_d = S_SETTLE;
                end else if (wait_q == c_WAIT_LAST) begin
                    hold_d  = c_HOLD_LOAD;
                    state_d = S_HOLD;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            S_SETTLE: begin
                if (!busy_s_q) begin
                    hold_d  = c_HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q <= 8'd1) begin
                    hold_d  = 8'd0;
                    state_d = S_STEP;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done   = (state_q == S_FIN);
        active = (state_q != S_IDLE);
    end

    assign div = div_q;
    assign gnt = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_clkdiv_ctrl
// Brief  : Randomized bench for clkdiv_ctrl with a ratio-path reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_clkdiv_ctrl;

    localparam int N         = 8;
    localparam int DIV_INIT  = 4;
    localparam int STEP_WAIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [N-1:0] div0, div1;
    logic         busy;
    logic [N-1:0] div;
    logic [1:0]   gnt;
    logic         done;
    logic         active;

    always #5 clk = ~clk;

    clkdiv_ctrl #(.n(N), .div_init(DIV_INIT), .step_wait(STEP_WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .div0(div0), .div1(div1), .busy(busy),
        .div(div), .gnt(gnt), .done(done), .active(active)
    );

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rel_cnt = 0;

    logic [1:0]   snap_req;
    logic [N-1:0] snap_d0, snap_d1;

    // Reference model state: the ratio path still owed for the current grant.
    int  path[$];
    int  div_log[$];
    int  gnt_log[$];
    int  mdl_div, mdl_tgt, mdl_last, w, exp_v;
    bit  in_txn, eq_txn, prev_done, timeout_mode;
    int  gnt_cyc, steps, last_change_cyc, last_fall_cyc, idle_pend;
    int  busy_rise, busy_fall;
    bit  busy_now;
    bit  cmd_pend [2];
    int  cmd_div  [2];

    task automatic chk(input string name, input int act, input int expv);
        n_tot++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic build_path(input int from, input int to);
        int cur;
        cur = from;
        path.delete();
        while (cur != to) begin
            if (cur == 0 || to == 0) cur = to;
            else cur = (to > cur) ? cur + 1 : cur - 1;
            path.push_back(cur);
        end
    endtask

    always @(posedge clk) begin
        snap_req <= req;
        snap_d0  <= div0;
        snap_d1  <= div1;
        if (!rst) rel_cnt <= 0;
        else if (rel_cnt < 100) rel_cnt <= rel_cnt + 1;
    end

    // Monitor, requester agents and downstream busy model, all on negedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("rst_div", int'(div), DIV_INIT);
                chk("rst_outs", int'({gnt, done, active}), 0);
                mdl_div = DIV_INIT; mdl_tgt = DIV_INIT; mdl_last = 1;
                path.delete(); in_txn = 0; prev_done = 0; idle_pend = 0; steps = 0;
                busy_rise = -1; busy_fall = -1; busy = 1'b0;
            end else begin
                if (gnt != 2'b00) begin
                    chk("gnt_onehot", int'($onehot(gnt)), 1);
                    chk("gnt_overlap", int'(in_txn), 0);
                    chk("gnt_startup", int'(rel_cnt >= 2), 1);
                    chk("gnt_req_seen", int'(snap_req != 2'b00), 1);
                    if (snap_req == 2'b11) w = (mdl_last == 1) ? 0 : 1;
                    else w = snap_req[1] ? 1 : 0;
                    chk("gnt_rr", int'(gnt), 1 << w);
                    mdl_last = w;
                    mdl_tgt  = (w == 1) ? int'(snap_d1) : int'(snap_d0);
                    build_path(mdl_div, mdl_tgt);
                    in_txn = 1; eq_txn = (path.size() == 0); gnt_cyc = cyc; steps = 0;
                    gnt_log.push_back(int'(gnt));
                end
                if (int'(div) != mdl_div) begin
                    if (path.size() == 0) begin
                        chk("div_unexpected", int'(div), mdl_div);
                    end else begin
                        exp_v = path.pop_front();
                        chk("div_step", int'(div), exp_v);
                        if (steps > 0) begin
                            if (timeout_mode)
                                chk("timeout_gap", int'(cyc - last_change_cyc >= 1024), 1);
                            else
                                chk("hold_gap", int'(last_fall_cyc > last_change_cyc &&
                                                     cyc - last_fall_cyc >= STEP_WAIT), 1);
                        end
                    end
                    steps++;
                    mdl_div = int'(div);
                    last_change_cyc = cyc;
                    div_log.push_back(int'(div));
                    busy_rise = cyc + 3;
                    busy_fall = busy_rise + int'($urandom_range(1, 4));
                end
                if (done) begin
                    chk("done_in_txn", int'(in_txn), 1);
                    chk("done_target", int'(path.size() == 0 && mdl_div == mdl_tgt), 1);
                    chk("done_single", int'(prev_done), 0);
                    if (eq_txn) chk("done_latency", int'(cyc - gnt_cyc <= 3), 1);
                    done_cnt++;
                end
                chk("active", int'(active), int'(in_txn));
                if (in_txn && (cyc - gnt_cyc > 6000)) begin
                    chk("txn_timeout", cyc - gnt_cyc, 6000);
                    in_txn = 0;
                end
                if (!in_txn && !done && req != 2'b00) idle_pend++;
                else idle_pend = 0;
                if (idle_pend > 4) begin
                    chk("grant_latency", idle_pend, 4);
                    idle_pend = 0;
                end
                if (done) in_txn = 0;
                prev_done = done;

                for (int k = 0; k < 2; k++) begin
                    if (gnt[k]) begin
                        req[k] = 1'b0;
                        if (k == 0) div0 = N'($urandom_range(0, 255));
                        else        div1 = N'($urandom_range(0, 255));
                    end else if (cmd_pend[k] && !req[k]) begin
                        if (k == 0) div0 = N'(cmd_div[0]);
                        else        div1 = N'(cmd_div[1]);
                        req[k] = 1'b1;
                        cmd_pend[k] = 1'b0;
                    end
                end

                busy_now = !timeout_mode && cyc >= busy_rise && cyc < busy_fall;
                if (busy && !busy_now) last_fall_cyc = cyc;
                busy = busy_now;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_dones(input int base, input int ndone, input int budget, input string name);
        int i;
        i = 0;
        while (done_cnt < base + ndone && i < budget) begin
            @(posedge clk);
            i++;
        end
        #2;
        chk(name, done_cnt - base, ndone);
    endtask

    task automatic run_req(input int mask, input int t0, input int t1, input int ndone,
                           input int budget, input string name);
        int base;
        base = done_cnt;
        if (mask[0]) begin cmd_div[0] = t0; cmd_pend[0] = 1'b1; end
        if (mask[1]) begin cmd_div[1] = t1; cmd_pend[1] = 1'b1; end
        wait_dones(base, ndone, budget, name);
    endtask

    task automatic clear_logs();
        div_log.delete();
        gnt_log.delete();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, i, mask;
        rst = 1'b0; req = 2'b00; div0 = '0; div1 = '0; busy = 1'b0;
        timeout_mode = 0; cmd_pend[0] = 0; cmd_pend[1] = 0;
        last_fall_cyc = 0; last_change_cyc = 0;
        repeat (3) @(posedge clk);
        #1 chk("reset_div", int'(div), DIV_INIT);
        chk("reset_active", int'(active), 0);
        #1 rst = 1'b1;

        // Ramp 4 -> 7 with busy handshakes.
        clear_logs();
        run_req(1, 7, 0, 1, 600, "s1_done");
        chk("s1_gnt", qat(gnt_log, 0), 1);
        chk("s1_steps", div_log.size(), 3);
        for (int k = 0; k < 3; k++) chk("s1_div_seq", qat(div_log, k), 5 + k);
        chk("s1_active_after", int'(active), 0);
        chk("s1_div_final", int'(div), 7);

        // Simultaneous requests after reset, then rotation.
        do_reset();
        clear_logs();
        run_req(3, 5, 3, 2, 800, "s2_done");
        chk("s2_first", qat(gnt_log, 0), 1);
        chk("s2_second", qat(gnt_log, 1), 2);
        clear_logs();
        run_req(1, 6, 0, 1, 800, "s2b_single");
        run_req(3, 2, 8, 2, 1500, "s2b_done");
        chk("s2b_tie_first", qat(gnt_log, 1), 2);
        chk("s2b_tie_second", qat(gnt_log, 2), 1);

        // Target equal to current ratio.
        do_reset();
        clear_logs();
        run_req(1, 4, 0, 1, 50, "s3_done");
        chk("s3_no_steps", div_log.size(), 0);
        chk("s3_gnt", qat(gnt_log, 0), 1);
        chk("s3_div", int'(div), 4);

        // Jumps through zero.
        run_req(1, 5, 0, 1, 300, "s4_to5");
        clear_logs();
        run_req(1, 0, 0, 1, 300, "s4_to0");
        chk("s4_jump0_n", div_log.size(), 1);
        chk("s4_jump0_v", qat(div_log, 0), 0);
        clear_logs();
        run_req(2, 0, 3, 1, 300, "s4_to3");
        chk("s4_jump3_n", div_log.size(), 1);
        chk("s4_jump3_v", qat(div_log, 0), 3);

        // No busy at all: each step completes by timeout.
        do_reset();
        timeout_mode = 1;
        clear_logs();
        run_req(1, 6, 0, 1, 5000, "s5_done");
        chk("s5_steps", div_log.size(), 2);
        chk("s5_v0", qat(div_log, 0), 5);
        chk("s5_v1", qat(div_log, 1), 6);
        timeout_mode = 0;

        // Reset mid-ramp with a pending request.
        do_reset();
        clear_logs();
        base = done_cnt;
        cmd_div[0] = 9; cmd_pend[0] = 1'b1;
        i = 0;
        while (gnt_log.size() < 1 && i < 100) begin @(posedge clk); i++; end
        #2 cmd_div[1] = 2; cmd_pend[1] = 1'b1;
        i = 0;
        while (div != N'(6) && i < 500) begin @(posedge clk); i++; end
        chk("s6_reached6", int'(div), 6);
        #2 rst = 1'b0;
        #1 chk("s6_div_rst", int'(div), DIV_INIT);
        chk("s6_active_rst", int'(active), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        i = 0;
        while (gnt_log.size() < 2 && i < 100) begin @(posedge clk); i++; end
        chk("s6_regrant", qat(gnt_log, 1), 2);
        wait_dones(base, 1, 500, "s6_done");
        chk("s6_div_final", int'(div), 2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            mask = int'($urandom_range(1, 3));
            run_req(mask, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    (mask == 3) ? 2 : 1, 3000, "rand_done");
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 The block SHALL take parameter n, default 8, as the width of every divider ratio port.
REQ-002 The block SHALL take parameter div_init, default 4, as the ratio driven on div after reset.
REQ-003 The block SHALL take parameter step_wait, default 4, as the clk cycles to hold after each settled step; legal range 1..255.
REQ-004 clk  input  1  system clock; all state changes on its posedge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low.
REQ-006 req  input  2  ratio-change request per requester; level, held until gnt.
REQ-007 div0  input  n  target ratio of requester 0.
REQ-008 div1  input  n  target ratio of requester 1.
REQ-009 busy  input  1  downstream programmable divider's reset output; asynchronous to clk.
REQ-010 div  output  n  ratio driven to the downstream divider.
REQ-011 gnt  output  2  one-hot, one-cycle acceptance pulse.
REQ-012 done  output  1  one-cycle pulse when div equals the accepted target and has settled.
REQ-013 active  output  1  high from the gnt cycle until the done cycle, inclusive.

Function
REQ-014 The block SHALL pass busy through a 2-flop synchronizer to form busy_s; it SHALL use no other busy path.
REQ-015 The FSM SHALL have states IDLE, STEP, ARM, SETTLE, HOLD, FIN.
REQ-016 In IDLE with any req bit high, the block SHALL grant one requester, pulse gnt the next cycle, latch that requester's div as tgt, and enter STEP.
REQ-017 Arbitration SHALL be round-robin: with both req high, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-018 A req arriving outside IDLE SHALL stay pending, without loss, until the FSM returns to IDLE.
REQ-019 In STEP, if div == tgt, the FSM SHALL go to FIN with div unchanged.
REQ-020 In STEP, if tgt == 0 or div == 0, div SHALL load tgt directly in one step; otherwise div SHALL move by exactly 1 toward tgt; the FSM SHALL then enter ARM.
REQ-021 Ratio arithmetic SHALL stay in n bits and never wrap: div never below 0 or above 2^n-1.
REQ-022 In ARM, the FSM SHALL wait for busy_s high, then enter SETTLE.
REQ-023 In SETTLE, the FSM SHALL wait for busy_s low, then load the hold counter with step_wait and enter HOLD.
REQ-024 In HOLD, the counter SHALL decrement each cycle; at 1 the FSM SHALL return to STEP.
REQ-025 An ARM wait of 1024 cycles with busy_s low SHALL be treated as settled and go straight to HOLD.
REQ-026 In FIN, the block SHALL pulse done for one cycle, set active low the following cycle, and return to IDLE.
REQ-027 The earliest re-grant SHALL be 1 cycle after done.
REQ-028 div0/div1 changes after gnt SHALL NOT affect the latched tgt.

Reset
REQ-029 While rst is low, the block SHALL drive div = div_init, gnt = 0, done = 0, active = 0, state = IDLE, hold counter 0, synchronizer flops 0, round-robin pointer to requester 1.
REQ-030 Reset asserted mid-ramp SHALL abandon the ramp immediately and return div to div_init.
REQ-031 After rst rises, the first grant SHALL occur no earlier than the second posedge of clk.

Verification
REQ-032 Reset, req=01, div0=7, busy model pulses 3 cycles after each div change -> gnt=01, div steps 4,5,6,7, each held at least step_wait cycles after busy falls, then one done pulse, active low after it.
REQ-033 req=11 simultaneously, twice in a row -> first gnt=01, second gnt=10; neither request lost.
REQ-034 Accepted target equal to current div (div0=4 after reset) -> gnt, then done within 3 cycles, div unchanged, no busy wait.
REQ-035 Target 0 from div=5, then target 3 from 0 -> single jump 5->0, then single jump 0->3, each with one ARM/SETTLE/HOLD pass.
REQ-036 busy held low permanently during ramp 4->6 -> each step completes via the 1024-cycle timeout, and done is still asserted.
REQ-037 rst pulsed low while div=6 mid-ramp toward 9 -> div=4 and active=0 immediately, and the pending req is re-granted after reset release.
